// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Hazard-request inputs and stage-control outputs of the
//               pipeline controller, bundled as one bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;
    logic        STALL;
    logic        BUBBLE;
    logic        BRANCH_TAKEN;
    logic        MDU_START;
    logic        MDU_DONE;
    logic        PC_WE;
    logic        IFID_WE;
    logic        IDEX_WE;
    logic        IFID_FLUSH;
    logic        IDEX_BUBBLE;
    logic        EXMEM_BUBBLE;
    logic [1:0]  STATE;
    logic        MDU_TIMEOUT;
    logic [31:0] STALL_CNT;
    logic [15:0] FLUSH_CNT;

    // Hazard unit / datapath side: raises requests, consumes controls
    modport master (
        output STALL, BUBBLE, BRANCH_TAKEN, MDU_START, MDU_DONE,
        input  PC_WE, IFID_WE, IDEX_WE, IFID_FLUSH, IDEX_BUBBLE, EXMEM_BUBBLE,
        input  STATE, MDU_TIMEOUT, STALL_CNT, FLUSH_CNT
    );

    // Controller side
    modport slave (
        input  STALL, BUBBLE, BRANCH_TAKEN, MDU_START, MDU_DONE,
        output PC_WE, IFID_WE, IDEX_WE, IFID_FLUSH, IDEX_BUBBLE, EXMEM_BUBBLE,
        output STATE, MDU_TIMEOUT, STALL_CNT, FLUSH_CNT
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Five-stage pipeline controller. Arbitrates branch flushes,
//               multi-cycle MUL/DIV freezes (with watchdog) and load-use
//               stalls into stage-register enables and NOP-insert controls,
//               and keeps stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int MDU_LIMIT = 40
) (
    input  logic           CLK,
    input  logic           RESET,
    pipeline_ctrl_if.slave bus
);

    // Watchdog only has to count up to MDU_LIMIT-1; the cycle that would
    // reach MDU_LIMIT raises the timeout instead of incrementing.
    localparam int                 c_wd_w      = (MDU_LIMIT < 2) ? 1 : $clog2(MDU_LIMIT);
    localparam logic [c_wd_w-1:0]  c_wd_last   = c_wd_w'(MDU_LIMIT - 1);
    localparam logic [15:0]        c_flush_max = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MDU_WAIT   = 2'b10,
        ST_FLUSH      = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_wd_w-1:0]   r_wd;
    logic                r_mdu_timeout;
    logic [31:0]         r_stall_cnt;
    logic [15:0]         r_flush_cnt;

    logic w_pc_we, w_ifid_we, w_idex_we;
    logic w_ifid_flush, w_idex_bubble, w_exmem_bubble;
    logic w_branch, w_mdu_enter, w_mdu_hold, w_mdu_timeout;

    // Event arbitration: reset > branch > MDU freeze > load-use stall
    always_comb begin
        w_pc_we        = 1'b1;
        w_ifid_we      = 1'b1;
        w_idex_we      = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_exmem_bubble = 1'b0;
        w_branch       = 1'b0;
        w_mdu_enter    = 1'b0;
        w_mdu_hold     = 1'b0;
        w_mdu_timeout  = 1'b0;
        w_next_state   = ST_RUN;

        if (RESET) begin
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_idex_we      = 1'b0;
            w_ifid_flush   = 1'b1;
            w_idex_bubble  = 1'b1;
            w_exmem_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN, ST_LOAD_STALL: begin
                    if (bus.BRANCH_TAKEN) begin
                        w_branch      = 1'b1;
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_next_state  = ST_FLUSH;
                    end else if (bus.MDU_START && !bus.MDU_DONE) begin
                        w_mdu_enter    = 1'b1;
                        w_pc_we        = 1'b0;
                        w_ifid_we      = 1'b0;
                        w_idex_we      = 1'b0;
                        w_exmem_bubble = 1'b1;
                        w_next_state   = ST_MDU_WAIT;
                    end else if (bus.STALL || bus.BUBBLE) begin
                        w_pc_we       = 1'b0;
                        w_ifid_we     = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_next_state  = ST_LOAD_STALL;
                    end
                end
                // Stall requests here come from squashed instructions
                ST_FLUSH: begin
                    if (bus.BRANCH_TAKEN) begin
                        w_branch      = 1'b1;
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_next_state  = ST_FLUSH;
                    end
                end
                // EX is frozen, so a branch cannot resolve here
                ST_MDU_WAIT: begin
                    if (!bus.MDU_DONE) begin
                        if (r_wd == c_wd_last) begin
                            w_mdu_timeout = 1'b1;
                        end else begin
                            w_mdu_hold     = 1'b1;
                            w_pc_we        = 1'b0;
                            w_ifid_we      = 1'b0;
                            w_idex_we      = 1'b0;
                            w_exmem_bubble = 1'b1;
                            w_next_state   = ST_MDU_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, watchdog, sticky timeout flag and performance counters
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_RUN;
            r_wd          <= '0;
            r_mdu_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_mdu_enter) begin
                r_wd <= '0;
            end else if (w_mdu_hold) begin
                r_wd <= r_wd + c_wd_w'(1);
            end
            if (w_mdu_timeout) begin
                r_mdu_timeout <= 1'b1;
            end
            if (!w_pc_we) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_branch && (r_flush_cnt != c_flush_max)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.PC_WE        = w_pc_we;
    assign bus.IFID_WE      = w_ifid_we;
    assign bus.IDEX_WE      = w_idex_we;
    assign bus.IFID_FLUSH   = w_ifid_flush;
    assign bus.IDEX_BUBBLE  = w_idex_bubble;
    assign bus.EXMEM_BUBBLE = w_exmem_bubble;
    assign bus.STATE        = r_state;
    assign bus.MDU_TIMEOUT  = r_mdu_timeout;
    assign bus.STALL_CNT    = r_stall_cnt;
    assign bus.FLUSH_CNT    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed, table-driven bench for pipeline_ctrl plus
//               hand-written MDU, timeout, reset and saturation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    // {PC_WE, IFID_WE, IDEX_WE, IFID_FLUSH, IDEX_BUBBLE, EXMEM_BUBBLE}
    localparam logic [5:0] O_D = 6'b111000;  // default
    localparam logic [5:0] O_R = 6'b000111;  // reset
    localparam logic [5:0] O_S = 6'b001010;  // load-use stall
    localparam logic [5:0] O_F = 6'b000001;  // MDU freeze
    localparam logic [5:0] O_B = 6'b111110;  // branch flush

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_LS  = 2'b01;
    localparam logic [1:0] S_MW  = 2'b10;
    localparam logic [1:0] S_FL  = 2'b11;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        bubble;
        logic        br;
        logic        ms;
        logic        md;
        logic [5:0]  o;
        logic [1:0]  st;
        logic [31:0] sc;
        logic [15:0] fc;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET;
    int   n_err    = 0;
    int   n_checks = 0;
    vec_t vecs[22];

    pipeline_ctrl_if bus();

    pipeline_ctrl #(.MDU_LIMIT(40)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] outs();
        return {bus.PC_WE, bus.IFID_WE, bus.IDEX_WE,
                bus.IFID_FLUSH, bus.IDEX_BUBBLE, bus.EXMEM_BUBBLE};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, settle, then check
    task automatic step(input logic rst, input logic st, input logic bu,
                        input logic br, input logic ms, input logic md);
        @(negedge CLK);
        RESET            = rst;
        bus.STALL        = st;
        bus.BUBBLE       = bu;
        bus.BRANCH_TAKEN = br;
        bus.MDU_START    = ms;
        bus.MDU_DONE     = md;
        #1;
    endtask

    task automatic chk_cyc(input string name, input logic [5:0] o, input logic [1:0] st);
        chk({name, "_outs"}, 32'(outs()), 32'(o));
        chk({name, "_state"}, 32'(bus.STATE), 32'(st));
    endtask

    initial begin
        RESET            = 1'b1;
        bus.STALL        = 1'b0;
        bus.BUBBLE       = 1'b0;
        bus.BRANCH_TAKEN = 1'b0;
        bus.MDU_START    = 1'b0;
        bus.MDU_DONE     = 1'b0;

        //          rst st bu br ms md  outs  state  stall_cnt flush_cnt
        vecs[0]  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, O_R, S_RUN, 32'd0, 16'd0};
        vecs[1]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_RUN, 32'd0, 16'd0};
        vecs[2]  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, O_S, S_RUN, 32'd0, 16'd0};
        vecs[3]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_LS,  32'd1, 16'd0};
        vecs[4]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_RUN, 32'd1, 16'd0};
        vecs[5]  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, O_S, S_RUN, 32'd1, 16'd0};
        vecs[6]  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, O_S, S_LS,  32'd2, 16'd0};
        vecs[7]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_LS,  32'd3, 16'd0};
        vecs[8]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_RUN, 32'd3, 16'd0};
        vecs[9]  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, O_B, S_RUN, 32'd3, 16'd0};
        vecs[10] = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, O_D, S_FL,  32'd3, 16'd1};
        vecs[11] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_RUN, 32'd3, 16'd1};
        vecs[12] = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, O_B, S_RUN, 32'd3, 16'd1};
        vecs[13] = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, O_B, S_FL,  32'd3, 16'd2};
        vecs[14] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_FL,  32'd3, 16'd3};
        vecs[15] = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, O_D, S_RUN, 32'd3, 16'd3};
        vecs[16] = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, O_R, S_RUN, 32'd3, 16'd3};
        vecs[17] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_RUN, 32'd0, 16'd0};
        vecs[18] = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, O_S, S_RUN, 32'd0, 16'd0};
        vecs[19] = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, O_B, S_LS,  32'd1, 16'd0};
        vecs[20] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_FL,  32'd1, 16'd1};
        vecs[21] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_D, S_RUN, 32'd1, 16'd1};

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].bubble,
                 vecs[i].br, vecs[i].ms, vecs[i].md);
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].o));
            chk($sformatf("vec%0d_state", i), 32'(bus.STATE), 32'(vecs[i].st));
            chk($sformatf("vec%0d_stall_cnt", i), bus.STALL_CNT, vecs[i].sc);
            chk($sformatf("vec%0d_flush_cnt", i), 32'(bus.FLUSH_CNT), 32'(vecs[i].fc));
            chk($sformatf("vec%0d_timeout", i), 32'(bus.MDU_TIMEOUT), 32'd0);
        end

        // Divide: 5 frozen cycles, branch ignored while waiting
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cyc("div_start", O_F, S_RUN);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0, (i == 2), 1'b1, 1'b0);
            chk_cyc($sformatf("div_wait%0d", i), O_F, S_MW);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_cyc("div_done", O_D, S_MW);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cyc("div_after", O_D, S_RUN);
        chk("div_stall_cnt", bus.STALL_CNT, 32'd5);
        chk("div_flush_cnt", 32'(bus.FLUSH_CNT), 32'd0);

        // Timeout: 40th wait cycle releases the pipeline and sets the flag
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cyc("to_start", O_F, S_RUN);
        for (int i = 1; i <= 39; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk_cyc($sformatf("to_wait%0d", i), O_F, S_MW);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cyc("to_expire", O_D, S_MW);
        chk("to_flag_pre", 32'(bus.MDU_TIMEOUT), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cyc("to_after", O_D, S_RUN);
        chk("to_flag", 32'(bus.MDU_TIMEOUT), 32'd1);
        chk("to_stall_cnt", bus.STALL_CNT, 32'd40);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_flag_sticky", 32'(bus.MDU_TIMEOUT), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_flag_cleared", 32'(bus.MDU_TIMEOUT), 32'd0);

        // Reset in the third wait cycle
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cyc("rw_start", O_F, S_RUN);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cyc("rw_wait2", O_F, S_MW);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cyc("rw_reset", O_R, S_MW);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cyc("rw_after", O_D, S_RUN);
        chk("rw_stall_cnt", bus.STALL_CNT, 32'd0);
        chk("rw_flush_cnt", 32'(bus.FLUSH_CNT), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cyc("rw_after2", O_D, S_RUN);

        // Flush counter saturation over 65537 accepted branches
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (65535) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("sat_65535", 32'(bus.FLUSH_CNT), 32'hFFFF);
        repeat (2) @(posedge CLK);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cyc("sat_end", O_D, S_FL);
        chk("sat_65537", 32'(bus.FLUSH_CNT), 32'hFFFF);
        chk("sat_stall_cnt", bus.STALL_CNT, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cyc("sat_run", O_D, S_RUN);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-003 SHALL have port STALL  in  1  load-use stall request from hazard unit.
REQ-004 SHALL have port BUBBLE  in  1  bubble-insert request from hazard unit.
REQ-005 SHALL have port BRANCH_TAKEN  in  1  taken branch/jump resolved in EX.
REQ-006 SHALL have port MDU_START  in  1  M-extension op present in EX this cycle.
REQ-007 SHALL have port MDU_DONE  in  1  multi-cycle MUL/DIV result valid.
REQ-008 SHALL have ports PC_WE, IFID_WE, IDEX_WE  out  1 each  stage-register write enables.
REQ-009 SHALL have ports IFID_FLUSH, IDEX_BUBBLE, EXMEM_BUBBLE  out  1 each  NOP-insert controls.
REQ-010 SHALL have port STATE  out  2  FSM state: RUN=00, LOAD_STALL=01, MDU_WAIT=10, FLUSH=11.
REQ-011 SHALL have port MDU_TIMEOUT  out  1  sticky watchdog error flag.
REQ-012 SHALL have ports STALL_CNT  out  32 and FLUSH_CNT  out  16  performance counters.
REQ-013 SHALL have parameter MDU_LIMIT, default 40, meaning max MDU_WAIT cycles before timeout.

Function
REQ-014 Default outputs (no event): PC_WE=IFID_WE=IDEX_WE=1, all flush/bubble outputs 0.
REQ-015 Event priority per cycle: RESET > BRANCH_TAKEN > MDU wait > STALL/BUBBLE.
REQ-016 RUN, BRANCH_TAKEN=1: same cycle PC_WE=1, IFID_FLUSH=1, IDEX_BUBBLE=1; next state FLUSH; FLUSH_CNT+1, saturating at 0xFFFF; MDU_START/STALL/BUBBLE ignored that cycle.
REQ-017 FLUSH: exactly one cycle, default outputs, STALL/BUBBLE ignored (computed from squashed instructions); next state RUN unless BRANCH_TAKEN=1 (re-apply REQ-016, stay FLUSH).
REQ-018 RUN, MDU_START=1, MDU_DONE=0: same cycle PC_WE=IFID_WE=IDEX_WE=0, EXMEM_BUBBLE=1; next state MDU_WAIT; watchdog counter cleared to 0.
REQ-019 RUN, MDU_START=1, MDU_DONE=1: single-cycle op, default outputs, stay RUN.
REQ-020 MDU_WAIT, MDU_DONE=0: outputs as REQ-018; watchdog +1 per cycle.
REQ-021 MDU_WAIT, MDU_DONE=1: default outputs that cycle; next state RUN.
REQ-022 MDU_WAIT, watchdog reaching MDU_LIMIT with MDU_DONE=0: set MDU_TIMEOUT=1 (sticky until RESET), default outputs that cycle, next state RUN.
REQ-023 BRANCH_TAKEN is ignored in MDU_WAIT (EX frozen, cannot resolve).
REQ-024 RUN or LOAD_STALL, STALL=1 or BUBBLE=1 (no higher event): same cycle PC_WE=IFID_WE=0, IDEX_BUBBLE=1; next state LOAD_STALL.
REQ-025 LOAD_STALL, STALL=0 and BUBBLE=0: default outputs, next state RUN.
REQ-026 STALL_CNT +1 every non-reset cycle with PC_WE=0; 32-bit wrap-around 0xFFFFFFFF -> 0.
REQ-027 STATE output is the registered FSM state; all other controls combinational from state and inputs.

Reset
REQ-028 RESET=1 at edge: STATE=RUN, watchdog=0, MDU_TIMEOUT=0, STALL_CNT=0, FLUSH_CNT=0.
REQ-029 While RESET=1: PC_WE=IFID_WE=IDEX_WE=0, IFID_FLUSH=IDEX_BUBBLE=EXMEM_BUBBLE=1, counters frozen.
REQ-030 RESET in any state (incl. mid MDU_WAIT) returns to RUN at next edge, no residual stall.

Verification
REQ-031 Load-use: RUN, STALL=1 one cycle -> PC_WE=0, IFID_WE=0, IDEX_BUBBLE=1; STATE=01 next; STALL_CNT=1; RUN after STALL drops.
REQ-032 Branch: RUN, BRANCH_TAKEN=1 with STALL=1 -> IFID_FLUSH=1, IDEX_BUBBLE=1, PC_WE=1; STATE=11 then 00; FLUSH_CNT=1; STALL_CNT=0.
REQ-033 Divide: MDU_START=1, MDU_DONE after 5 cycles -> 5 frozen cycles (PC_WE=0, EXMEM_BUBBLE=1), STATE=10 four cycles, STALL_CNT=5, RUN after.
REQ-034 Timeout: MDU_LIMIT=40, MDU_DONE never -> MDU_TIMEOUT=1 after 40 MDU_WAIT cycles, STATE=00, flag persists until RESET.
REQ-035 Reset mid MDU_WAIT: RESET at wait cycle 3 -> reset outputs per REQ-029, then STATE=00, counters 0, default outputs.
REQ-036 Saturation: 65537 accepted branches -> FLUSH_CNT=0xFFFF held.
